// File: rtl/quad_updown_decoder.sv
// quad_updown_decoder: synchronized A/B quadrature decode into a wrapping up/down position count
module quad_updown_decoder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic             dir,
  output logic             step,
  output logic             err,
  output logic             wrap
);
  logic [1:0]       s1_q, s2_q, prev_q, chg;
  logic             v1_q, v2_q, init_q, up, cnt;
  logic [WIDTH-1:0] q_q, q_d;
  logic             dir_q, dir_d, step_q, step_d, err_q, err_d, wrap_q, wrap_d;
  // Up when the new A differs from the old B; only single-bit changes are legal
  always_comb begin
    chg    = prev_q ^ s2_q;
    up     = s2_q[1] ^ prev_q[0];
    cnt    = init_q & en & (chg[1] ^ chg[0]);
    err_d  = init_q & (&chg);
    step_d = cnt;
    dir_d  = cnt ? up : dir_q;
    q_d    = clr ? '0 : cnt ? (up ? q_q + WIDTH'(1) : q_q - WIDTH'(1)) : q_q;
    wrap_d = ~clr & cnt & (up ? (&q_q) : (q_q == '0));
  end
  // v1/v2 follow the sampled data so the seed is taken from a real sample, not the reset value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q   <= 2'b00;
      s2_q   <= 2'b00;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      prev_q <= 2'b00;
      init_q <= 1'b0;
      q_q    <= '0;
      dir_q  <= 1'b0;
      step_q <= 1'b0;
      err_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      s1_q   <= {a, b};
      s2_q   <= s1_q;
      v1_q   <= 1'b1;
      v2_q   <= v1_q;
      prev_q <= s2_q;
      init_q <= init_q | v2_q;
      q_q    <= q_d;
      dir_q  <= dir_d;
      step_q <= step_d;
      err_q  <= err_d;
      wrap_q <= wrap_d;
    end
  end
  assign q    = q_q;
  assign dir  = dir_q;
  assign step = step_q;
  assign err  = err_q;
  assign wrap = wrap_q;
endmodule

// File: tb/tb_quad_updown_decoder.sv
// tb_quad_updown_decoder: directed quadrature vectors checked by a queue scoreboard on step/err events
module tb_quad_updown_decoder;
  logic       clk = 1'b0, rst, a, b, en, clr;
  logic [3:0] q;
  logic       dir, step, err, wrap;
  int         checks = 0, errors = 0, cyc = 0;
  typedef struct {
    int         cyc;
    logic [3:0] q;
    logic       dir, wrap, err;
  } ev_t;
  ev_t sb[$];

  quad_updown_decoder #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .en(en), .clr(clr),
    .q(q), .dir(dir), .step(step), .err(err), .wrap(wrap)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst && (step || err)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d got q=%0d dir=%0b wrap=%0b err=%0b step=%0b, required no event",
                 cyc, q, dir, wrap, err, step);
      end else begin
        ev_t e;
        e = sb.pop_front();
        if (cyc != e.cyc || q != e.q || dir != e.dir || wrap != e.wrap || err != e.err || step != !e.err) begin
          errors++;
          $display("FAIL event got cyc=%0d q=%0d dir=%0b wrap=%0b err=%0b step=%0b, required cyc=%0d q=%0d dir=%0b wrap=%0b err=%0b step=%0b",
                   cyc, q, dir, wrap, err, step, e.cyc, e.q, e.dir, e.wrap, e.err, !e.err);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, act, req);
    end
  endtask

  task automatic drv(input logic [1:0] ab, input logic ev, input logic [3:0] eq,
                     input logic ed, input logic ew, input logic ee, input logic c);
    ev_t e;
    @(negedge clk);
    a = ab[1];
    b = ab[0];
    if (ev) begin
      e.cyc = cyc + 3;
      e.q = eq;
      e.dir = ed;
      e.wrap = ew;
      e.err = ee;
      sb.push_back(e);
    end
    @(negedge clk);
    @(negedge clk);
    if (c) clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; a = 1'b1; b = 1'b1; en = 1'b1; clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_q", q, 0);
    chk("reset_pulses", {dir, step, err, wrap}, 0);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("seed_q", q, 0);
    chk("seed_pulses", {step, err, wrap}, 0);
    @(negedge clk);
    a = 1'b0; b = 1'b0;
    #2 rst = 1'b0;
    #2 chk("async_reset_q", q, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    drv(2'b10, 1, 4'd1, 1, 0, 0, 0);
    drv(2'b11, 1, 4'd2, 1, 0, 0, 0);
    drv(2'b01, 1, 4'd3, 1, 0, 0, 0);
    drv(2'b00, 1, 4'd4, 1, 0, 0, 0);
    chk("up4_q", q, 4);
    chk("up4_dir", dir, 1);
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    chk("idle_clr_q", q, 0);
    drv(2'b01, 1, 4'd15, 0, 1, 0, 0);
    drv(2'b00, 1, 4'd0, 1, 1, 0, 0);
    drv(2'b11, 1, 4'd0, 1, 0, 1, 0);
    drv(2'b01, 1, 4'd1, 1, 0, 0, 0);
    en = 1'b0;
    drv(2'b00, 0, 4'd0, 0, 0, 0, 0);
    drv(2'b10, 0, 4'd0, 0, 0, 0, 0);
    chk("en0_q", q, 1);
    chk("en0_dir", dir, 1);
    en = 1'b1;
    drv(2'b11, 1, 4'd2, 1, 0, 0, 0);
    drv(2'b01, 1, 4'd3, 1, 0, 0, 0);
    drv(2'b00, 1, 4'd4, 1, 0, 0, 0);
    drv(2'b10, 1, 4'd5, 1, 0, 0, 0);
    drv(2'b11, 1, 4'd6, 1, 0, 0, 0);
    drv(2'b01, 1, 4'd7, 1, 0, 0, 0);
    drv(2'b00, 1, 4'd0, 1, 0, 0, 1);
    drv(2'b01, 1, 4'd0, 0, 0, 0, 1);
    chk("clr_down_q", q, 0);
    chk("clr_down_dir", dir, 0);
    repeat (4) @(negedge clk);
    chk("pending_events", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
